// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : ma drive-code constants and decoder FSM state encoding,
//               shared between the PWM driver and pwm_decoder.
// Revision    : 1.0
// ============================================================================
package pwm_pkg;

    localparam logic [1:0] MA_OFF = 2'b00;
    localparam logic [1:0] MA_FWD = 2'b01;
    localparam logic [1:0] MA_REV = 2'b10;
    localparam logic [1:0] MA_LOW = 2'b11;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_EDGE = 2'd1;
    localparam logic [1:0] c_MEASURE   = 2'd2;
    localparam logic [1:0] c_STALL     = 2'd3;

    // Pulse is high only for the two driving codes; OFF and LOW both read as 0.
    function automatic logic code_pulse(input logic [1:0] code);
        return (code != MA_OFF) && (code != MA_LOW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_decoder_if
// Description : ma drive pair in, decoded measurement/status bundle out.
// Revision    : 1.0
// ============================================================================
interface pwm_decoder_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       ma;
    logic             active;
    logic             direct;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             stall;
    logic             stall_lvl;

    modport master (
        output ma,
        input  active, direct, period, high_time, meas_valid, stall, stall_lvl
    );

    modport slave (
        input  ma,
        output active, direct, period, high_time, meas_valid, stall, stall_lvl
    );
endinterface
`default_nettype wire

// File: rtl/pwm_sync_deglitch.sv
`default_nettype none
// ============================================================================
// Module      : pwm_sync_deglitch
// Description : 2-flop synchronizer for ma followed by a stability filter that
//               accepts a code after DEGLITCH identical synchronized samples.
// Revision    : 1.0
// ============================================================================
module pwm_sync_deglitch
    import pwm_pkg::*;
#(
    parameter int DEGLITCH = 2
) (
    input  wire logic       sclk,
    input  wire logic       s_rst,
    input  wire logic [1:0] ma,
    output logic      [1:0] code
);

    localparam logic [3:0] c_DG = 4'(DEGLITCH);

    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_last;
    logic [1:0] r_code;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    // Run length of the current synchronized value, counting this sample.
    always_comb begin
        w_cnt_nxt = 4'd1;
        if (r_sync2 == r_last) begin
            w_cnt_nxt = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
        end
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            r_sync1 <= MA_OFF;
            r_sync2 <= MA_OFF;
            r_last  <= MA_OFF;
            r_code  <= MA_OFF;
            r_cnt   <= 4'd0;
        end else begin
            r_sync1 <= ma;
            r_sync2 <= r_sync1;
            r_last  <= r_sync2;
            r_cnt   <= w_cnt_nxt;
            if (w_cnt_nxt >= c_DG) begin
                r_code <= r_sync2;
            end
        end
    end

    assign code = r_code;

endmodule
`default_nettype wire

// File: rtl/pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : pwm_decoder
// Description : Recovers direction, period and high time from a motor drive
//               pair, with stall detection for static levels.
// Revision    : 1.0
// ============================================================================
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int DEGLITCH = 2,
    parameter int TIMEOUT  = 60000
) (
    input  wire logic  sclk,
    input  wire logic  s_rst,
    pwm_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [1:0]       w_code;
    logic             w_pulse;
    logic             w_rise;
    logic             w_dir;
    logic             w_dir_change;
    logic             w_start;
    logic             w_emit;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_pcnt_inc;
    logic [CNT_W-1:0] w_hcnt_inc;

    logic [1:0]       r_state;
    logic             r_pulse_d;
    logic             r_dir_hold;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_meas_valid;
    logic             r_stall_lvl;

    pwm_sync_deglitch #(
        .DEGLITCH (DEGLITCH)
    ) u_sync (
        .sclk  (sclk),
        .s_rst (s_rst),
        .ma    (bus.ma),
        .code  (w_code)
    );

    // Direction follows the driving codes at once and is held through LOW/OFF.
    assign w_pulse      = code_pulse(w_code);
    assign w_rise       = w_pulse & ~r_pulse_d;
    assign w_dir        = w_pulse ? (w_code == MA_FWD) : r_dir_hold;
    assign w_dir_change = w_pulse && ((w_code == MA_FWD) != r_dir_hold);
    assign w_pcnt_inc   = (&r_pcnt) ? r_pcnt : r_pcnt + c_ONE;
    assign w_hcnt_inc   = (&r_hcnt) ? r_hcnt : r_hcnt + c_ONE;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_code != MA_OFF) w_state_nxt = c_WAIT_EDGE;
            end
            c_WAIT_EDGE: begin
                if (w_rise)                   w_state_nxt = c_MEASURE;
                else if (r_pcnt >= c_TIMEOUT) w_state_nxt = c_STALL;
            end
            c_MEASURE: begin
                if (w_dir_change)             w_state_nxt = c_WAIT_EDGE;
                else if (w_rise)              w_state_nxt = c_MEASURE;
                else if (r_pcnt >= c_TIMEOUT) w_state_nxt = c_STALL;
            end
            default: begin
                if (w_rise) w_state_nxt = c_MEASURE;
            end
        endcase
        if (w_code == MA_OFF) w_state_nxt = c_IDLE;
    end

    assign w_emit  = (r_state == c_MEASURE) && w_rise && !w_dir_change;
    assign w_start = w_rise && (w_state_nxt == c_MEASURE) && (r_state != c_IDLE);

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            r_state      <= c_IDLE;
            r_pulse_d    <= 1'b0;
            r_dir_hold   <= 1'b0;
            r_pcnt       <= '0;
            r_hcnt       <= '0;
            r_period     <= '0;
            r_high       <= '0;
            r_meas_valid <= 1'b0;
            r_stall_lvl  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pulse_d    <= w_pulse;
            r_dir_hold   <= w_dir;
            r_meas_valid <= w_emit;
            r_stall_lvl  <= (w_state_nxt == c_STALL) ? w_pulse : 1'b0;
            if (w_emit) begin
                r_period <= r_pcnt;
                r_high   <= r_hcnt;
            end
            // A discarded measurement restarts from zero just like IDLE.
            if ((w_state_nxt == c_IDLE) ||
                ((r_state == c_MEASURE) && (w_state_nxt == c_WAIT_EDGE))) begin
                r_pcnt <= '0;
                r_hcnt <= '0;
            end else if (w_start) begin
                r_pcnt <= c_ONE;
                r_hcnt <= c_ONE;
            end else if ((r_state == c_WAIT_EDGE) || (r_state == c_MEASURE)) begin
                r_pcnt <= w_pcnt_inc;
                if (w_pulse) r_hcnt <= w_hcnt_inc;
            end
        end
    end

    assign bus.active     = (w_code != MA_OFF);
    assign bus.direct     = w_dir;
    assign bus.period     = r_period;
    assign bus.high_time  = r_high;
    assign bus.meas_valid = r_meas_valid;
    assign bus.stall      = (r_state == c_STALL);
    assign bus.stall_lvl  = r_stall_lvl;

endmodule
`default_nettype wire

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 Parameter CNT_W, default 16, width of period/high-time counters and outputs.
REQ-002 Parameter DEGLITCH, default 2, consecutive sclk cycles a synchronized ma code must be stable before acceptance (range 1..15).
REQ-003 Parameter TIMEOUT, default 16'd60000, sclk cycles without a pulse rising edge before STALL (must be < 2^CNT_W - 1).
REQ-004 sclk  in  1  single clock; all logic on rising edge.
REQ-005 s_rst  in  1  reset, asynchronous, active-high.
REQ-006 ma  in  2  motor drive pair from the PWM driver, asynchronous to sclk.
REQ-007 active  out  1  accepted code != 2'b00.
REQ-008 direct  out  1  recovered direction.
REQ-009 period  out  CNT_W  last measured rising-to-rising period, sclk cycles.
REQ-010 high_time  out  CNT_W  last measured pulse-high duration, sclk cycles.
REQ-011 meas_valid  out  1  one-cycle strobe when period/high_time update.
REQ-012 stall  out  1  active but no pulse edge for TIMEOUT cycles.
REQ-013 stall_lvl  out  1  static pulse level while stall=1 (1 = 100 % duty, 0 = 0 %).

Function
REQ-014 ma SHALL pass a 2-flop synchronizer, then a deglitch stage; the accepted code changes only after the synchronized code holds a new value for DEGLITCH consecutive cycles.
REQ-015 Decode of accepted code: 00 -> disabled; 01 -> pulse=1, direct=1; 10 -> pulse=1, direct=0; 11 -> pulse=0, direct held.
REQ-016 FSM states: IDLE, WAIT_EDGE, MEASURE, STALL.
REQ-017 IDLE: entered on accepted 00 from any state; clears counters, stall=0; exits to WAIT_EDGE when code != 00.
REQ-018 WAIT_EDGE: waits for pulse 0->1; on edge -> MEASURE with period counter = 1 and high counter = 1; no measurement is emitted for the first edge.
REQ-019 MEASURE: period counter increments every cycle; high counter increments while pulse=1; on next pulse 0->1, latch period and high_time, pulse meas_valid the following cycle, restart counters at 1.
REQ-020 meas_valid latency: exactly SYNC(2)+DEGLITCH+1 sclk cycles after the ma transition that produced the rising edge.
REQ-021 A direction change (01<->10 accepted, either directly or via 11) during MEASURE SHALL discard the in-progress measurement and return to WAIT_EDGE; direct updates immediately.
REQ-022 If period counter reaches TIMEOUT in WAIT_EDGE or MEASURE -> STALL; stall=1, stall_lvl = current pulse, period and high_time hold last values, no meas_valid.
REQ-023 STALL exits to MEASURE on pulse 0->1 (counters restart at 1, stall=0); to IDLE on code 00.
REQ-024 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-025 Simultaneous accepted 00 and TIMEOUT: IDLE wins.
REQ-026 period and high_time SHALL hold between strobes; high_time <= period always.

Reset
REQ-027 On s_rst=1 asynchronously: synchronizer/deglitch regs = 2'b00, state = IDLE, active=0, direct=0, period=0, high_time=0, meas_valid=0, stall=0, stall_lvl=0.
REQ-028 Reset deassertion mid-PWM stream SHALL produce no meas_valid until two accepted rising edges have been observed.

Structure
REQ-029 Shared package pwm_pkg SHALL hold the FSM state encoding and the ma code constants (MA_OFF=00, MA_FWD=01, MA_REV=10, MA_LOW=11), shared with the driver.
REQ-030 Sub-module pwm_sync_deglitch (2-bit synchronizer + DEGLITCH filter) SHALL be a separate instance; FSM and counters in pwm_decoder.

Verification
REQ-031 ma toggles 01 (25 cycles) / 11 (75 cycles), 4 periods -> 3 strobes, period=100, high_time=25, direct=1, active=1.
REQ-032 Same waveform with 10/11, then switch to 01 mid-period -> measurement discarded, direct=1, next strobe after two new rising edges with period=100.
REQ-033 ma held 01 for 60000+ cycles after one edge -> stall=1, stall_lvl=1, period/high_time unchanged; resume toggling -> stall=0, strobe after next full period.
REQ-034 1-cycle glitch 01->00->01 with DEGLITCH=2 -> no state change, active stays 1, measurements continue.
REQ-035 Assert s_rst mid-MEASURE -> all outputs 0 within same cycle; after release, first strobe only after second rising edge.
REQ-036 ma=00 for 10 cycles during MEASURE -> active=0, IDLE, no strobe; code 01 again -> WAIT_EDGE.
